// File: rtl/branch_queue_pkg.sv
// Shared types and constants for the in-flight branch queue.
//   PATTERN_WIDTH  : PHT index width
//   INST_MEM_WIDTH : instruction address width
//   BQ_DEPTH       : default number of branches in flight
//   branch_entry_t : one queued branch {pattern, prediction, alt_addr}
//   is_mispredict  : compares the actual outcome with the prediction's direction bit
package branch_queue_pkg;

  localparam int PATTERN_WIDTH  = 10;
  localparam int INST_MEM_WIDTH = 16;
  localparam int BQ_DEPTH       = 4;

  typedef struct packed {
    logic [PATTERN_WIDTH-1:0]  pattern;
    logic [1:0]                prediction;
    logic [INST_MEM_WIDTH-1:0] alt_addr;
  } branch_entry_t;

  // Bit 1 of the 2-bit saturating counter is the predicted direction.
  function automatic logic is_mispredict(input logic [1:0] prediction, input logic taken);
    return taken ^ prediction[1];
  endfunction

endpackage

// File: rtl/bq_ptr.sv
// Head/tail/count bookkeeping for the branch queue.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_push         : push request from fetch
//   i_pop          : resolve request from the branch unit
//   i_flush        : misprediction flush (drops push/pop, empties the queue)
//   o_head, o_tail : read / write pointers
//   o_full         : count == DEPTH
//   o_push_acc     : push actually accepted this cycle
//   o_pop_acc      : pop actually accepted this cycle
module bq_ptr #(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  output logic [PW-1:0] o_head,
  output logic [PW-1:0] o_tail,
  output logic          o_full,
  output logic          o_push_acc,
  output logic          o_pop_acc
);

  localparam int CW = PW + 1;

  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          w_empty;
  logic          w_pop_acc;
  logic          w_push_acc;

  assign o_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  assign w_pop_acc  = i_pop && !w_empty && !i_flush;
  // At full a push is still accepted when the head is leaving in the same
  // cycle: the slot being written is the one being freed.
  assign w_push_acc = i_push && !i_flush && (!o_full || w_pop_acc);

  assign o_head     = r_head;
  assign o_tail     = r_tail;
  assign o_pop_acc  = w_pop_acc;
  assign o_push_acc = w_push_acc;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= r_tail;
      r_count <= '0;
    end else begin
      if (w_push_acc) r_tail <= r_tail + PW'(1);
      if (w_pop_acc)  r_head <= r_head + PW'(1);
      case ({w_push_acc, w_pop_acc})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always @(posedge i_clk) begin
    if (i_rst_n) begin
      assert (!(i_push && o_full && !w_pop_acc && !i_flush))
        else $warning("bq_ptr: push while full dropped");
      assert (!(i_pop && w_empty && !i_flush))
        else $warning("bq_ptr: resolve while empty ignored");
    end
  end

endmodule

// File: rtl/branch_queue.sv
// In-order FIFO of in-flight conditional branches between fetch and the
// branch unit. Pops the head on resolve, reports commit and misprediction
// one cycle later, and flushes all younger entries on a misprediction.
//   i_clk, i_rst_n      : clock, synchronous active-low reset
//   i_push              : conditional branch leaves fetch
//   i_push_pattern      : PHT index of that branch
//   i_push_prediction   : 2-bit prediction of that branch
//   i_push_alt_addr     : non-predicted path address
//   o_full              : queue holds DEPTH branches, fetch must stall
//   i_resolve           : oldest branch resolves this cycle
//   i_resolve_taken     : actual outcome of that branch
//   o_commit_b          : pulse, a branch resolved last cycle
//   o_pattern_end       : PHT index of the committed branch
//   o_prediction_end    : prediction of the committed branch
//   o_failure           : committed branch was mispredicted
//   o_addr_on_failure   : restart address
module branch_queue
  import branch_queue_pkg::*;
#(
  parameter int DEPTH = BQ_DEPTH
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_push,
  input  logic [PATTERN_WIDTH-1:0]  i_push_pattern,
  input  logic [1:0]                i_push_prediction,
  input  logic [INST_MEM_WIDTH-1:0] i_push_alt_addr,
  output logic                      o_full,
  input  logic                      i_resolve,
  input  logic                      i_resolve_taken,
  output logic                      o_commit_b,
  output logic [PATTERN_WIDTH-1:0]  o_pattern_end,
  output logic [1:0]                o_prediction_end,
  output logic                      o_failure,
  output logic [INST_MEM_WIDTH-1:0] o_addr_on_failure
);

  localparam int PW = $clog2(DEPTH);

  branch_entry_t r_mem [DEPTH];
  branch_entry_t w_head_entry;
  branch_entry_t w_push_entry;

  logic [PW-1:0] w_head;
  logic [PW-1:0] w_tail;
  logic          w_push_acc;
  logic          w_pop_acc;

  logic                      r_commit_b;
  logic                      r_failure;
  logic [PATTERN_WIDTH-1:0]  r_pattern_end;
  logic [1:0]                r_prediction_end;
  logic [INST_MEM_WIDTH-1:0] r_addr_on_failure;

  bq_ptr #(
    .DEPTH (DEPTH)
  ) u_ptr (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_push     (i_push),
    .i_pop      (i_resolve),
    .i_flush    (r_failure),
    .o_head     (w_head),
    .o_tail     (w_tail),
    .o_full     (o_full),
    .o_push_acc (w_push_acc),
    .o_pop_acc  (w_pop_acc)
  );

  assign w_push_entry = '{pattern:    i_push_pattern,
                          prediction: i_push_prediction,
                          alt_addr:   i_push_alt_addr};

  // Storage is not reset; only entries between head and tail are ever read.
  always_ff @(posedge i_clk) begin
    if (w_push_acc) r_mem[w_tail] <= w_push_entry;
  end

  assign w_head_entry = r_mem[w_head];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_commit_b        <= 1'b0;
      r_failure         <= 1'b0;
      r_pattern_end     <= '0;
      r_prediction_end  <= '0;
      r_addr_on_failure <= '0;
    end else if (w_pop_acc) begin
      r_commit_b        <= 1'b1;
      r_failure         <= is_mispredict(w_head_entry.prediction, i_resolve_taken);
      r_pattern_end     <= w_head_entry.pattern;
      r_prediction_end  <= w_head_entry.prediction;
      r_addr_on_failure <= w_head_entry.alt_addr;
    end else begin
      // Data outputs hold so the last commit stays observable.
      r_commit_b <= 1'b0;
      r_failure  <= 1'b0;
    end
  end

  assign o_commit_b        = r_commit_b;
  assign o_failure         = r_failure;
  assign o_pattern_end     = r_pattern_end;
  assign o_prediction_end  = r_prediction_end;
  assign o_addr_on_failure = r_addr_on_failure;

endmodule
